stereo_echo: RTL and testbench

Parametrised stereo echo engine with independent per-channel delay, runtime wet and feedback gains, signed saturating arithmetic, bypass, and a self-clearing delay memory. It sits between the audio core's left/right source streams and its sink streams. Each channel keeps a circular buffer and emits one processed sample per accepted input sample.

---
 rtl/echo_pkg.sv | 24 ++
 rtl/echo_channel.sv | 146 ++++++++++++++
 rtl/stereo_echo.sv | 104 ++++++++++
 tb/tb_stereo_echo.sv | 570 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_pkg.sv
// rtl/echo_pkg.sv - shared constants and helpers for the stereo echo engine
package echo_pkg;

    localparam int DEF_DATA_W = 24;
    localparam int DEF_GAIN_W = 8;

    // Guard bits carried above the sample width so x + echo never wraps before clamping
    localparam int SAT_GUARD_W = 2;

    // Saturation limits for the default sample width
    localparam logic signed [DEF_DATA_W-1:0] DEF_SAT_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
    localparam logic signed [DEF_DATA_W-1:0] DEF_SAT_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};

    // Per-channel FSM encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_CALC  = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/echo_channel.sv
// rtl/echo_channel.sv - one echo channel: FSM, circular delay RAM, gain and saturation datapath
import echo_pkg::*;

module echo_channel #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = 15,
    parameter int GAIN_W = DEF_GAIN_W,
    parameter int DELAY  = 24000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_busy,
    input  logic                     i_abort,
    input  logic [ADDR_W-1:0]        i_clr_addr,
    input  logic signed [DATA_W-1:0] i_data,
    input  logic                     i_dv,
    input  logic [GAIN_W-1:0]        i_wet_gain,
    input  logic [GAIN_W-1:0]        i_fb_gain,
    input  logic                     i_bypass,
    output logic signed [DATA_W-1:0] o_echo,
    output logic                     o_dv,
    output logic                     o_idle
);

    localparam int SUM_W  = DATA_W + SAT_GUARD_W;
    localparam int PROD_W = DATA_W + GAIN_W + 1;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DELAY - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SAT_GUARD_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SAT_GUARD_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic [1:0]               state;
    logic [ADDR_W-1:0]        ptr;
    logic signed [DATA_W-1:0] x_r;
    logic signed [DATA_W-1:0] y_r;
    logic signed [DATA_W-1:0] w_r;
    logic                     flush;

    logic signed [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0]        ram_addr;
    logic [ADDR_W-1:0]        addr_q;
    logic                     ram_we;
    logic signed [DATA_W-1:0] ram_wdata;
    logic signed [DATA_W-1:0] ram_q;

    logic signed [PROD_W-1:0] d_ext;
    logic signed [PROD_W-1:0] wet_p;
    logic signed [PROD_W-1:0] fbk_p;
    logic signed [SUM_W-1:0]  wet_v;
    logic signed [SUM_W-1:0]  fbk_v;
    logic signed [SUM_W-1:0]  x_ext;
    logic signed [SUM_W-1:0]  sum_y;
    logic signed [SUM_W-1:0]  sum_w;
    logic signed [DATA_W-1:0] y_n;
    logic signed [DATA_W-1:0] w_n;

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [SUM_W-1:0] v);
        if (v > SAT_MAX) begin
            sat = SAT_MAX[DATA_W-1:0];
        end else if (v < SAT_MIN) begin
            sat = SAT_MIN[DATA_W-1:0];
        end else begin
            sat = v[DATA_W-1:0];
        end
    endfunction

    // A clear sweep or a clear pulse abandons any sample in flight
    assign flush  = i_busy | i_abort;
    assign o_idle = (state == ST_IDLE);

    // Single RAM port: the sweep owns it while busy, otherwise it follows the channel pointer
    always_comb begin
        ram_addr  = i_busy ? i_clr_addr : ptr;
        ram_we    = i_busy | ((state == ST_WRITE) & ~i_abort);
        ram_wdata = i_busy ? '0 : w_r;
    end

    // Delay RAM with registered address; the read of ptr lands well before the write back
    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        addr_q <= ram_addr;
    end

    assign ram_q = mem[addr_q];

    // Echo tap scaled by both gains, then mixed with the dry sample and clamped
    always_comb begin
        d_ext = {{(GAIN_W+1){ram_q[DATA_W-1]}}, ram_q};
        wet_p = d_ext * $signed({{(DATA_W+1){1'b0}}, i_wet_gain});
        fbk_p = d_ext * $signed({{(DATA_W+1){1'b0}}, i_fb_gain});
        wet_v = SUM_W'(wet_p >>> GAIN_W);
        fbk_v = SUM_W'(fbk_p >>> GAIN_W);
        x_ext = {{SAT_GUARD_W{x_r[DATA_W-1]}}, x_r};
        sum_y = x_ext + wet_v;
        sum_w = x_ext + fbk_v;
        y_n   = i_bypass ? x_r : sat(sum_y);
        w_n   = sat(sum_w);
    end

    // Sample FSM: IDLE -> READ -> CALC -> WRITE, one output strobe per accepted input
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            x_r    <= '0;
            y_r    <= '0;
            w_r    <= '0;
            o_echo <= '0;
            o_dv   <= 1'b0;
        end else begin
            o_dv <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
                ptr   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_dv) begin
                            x_r   <= i_data;
                            state <= ST_READ;
                        end
                    end
                    ST_READ: begin
                        state <= ST_CALC;
                    end
                    ST_CALC: begin
                        y_r   <= y_n;
                        w_r   <= w_n;
                        state <= ST_WRITE;
                    end
                    ST_WRITE: begin
                        o_echo <= y_r;
                        o_dv   <= 1'b1;
                        ptr    <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
                        state  <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/stereo_echo.sv
// rtl/stereo_echo.sv - stereo echo top: two channels, clear sequencer, busy and overrun flags
import echo_pkg::*;

module stereo_echo #(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = 15,
    parameter int DELAY_L = 24000,
    parameter int DELAY_R = 18000,
    parameter int GAIN_W  = DEF_GAIN_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic signed [DATA_W-1:0] i_data_L,
    input  logic signed [DATA_W-1:0] i_data_R,
    input  logic                     i_L_DV,
    input  logic                     i_R_DV,
    input  logic [GAIN_W-1:0]        i_wet_gain,
    input  logic [GAIN_W-1:0]        i_fb_gain,
    input  logic                     i_bypass,
    input  logic                     i_clear,
    output logic signed [DATA_W-1:0] o_echo_L,
    output logic signed [DATA_W-1:0] o_echo_R,
    output logic                     o_L_DV,
    output logic                     o_R_DV,
    output logic                     o_busy,
    output logic                     o_overrun
);

    localparam int MAX_DELAY = max_int(DELAY_L, DELAY_R);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(MAX_DELAY - 1);

    logic [ADDR_W-1:0] clr_addr;
    logic              l_idle;
    logic              r_idle;

    // Clear sweep: zero addresses 0..MAX_DELAY-1, restarting on reset release or a clear pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_busy   <= 1'b1;
            clr_addr <= '0;
        end else if (i_clear) begin
            o_busy   <= 1'b1;
            clr_addr <= '0;
        end else if (o_busy) begin
            if (clr_addr == CLR_LAST) begin
                o_busy <= 1'b0;
            end else begin
                clr_addr <= clr_addr + 1'b1;
            end
        end
    end

    // Sticky overrun: a strobe arrived while its channel was still working on a sample
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overrun <= 1'b0;
        end else if (!o_busy && ((i_L_DV && !l_idle) || (i_R_DV && !r_idle))) begin
            o_overrun <= 1'b1;
        end
    end

    echo_channel #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .GAIN_W (GAIN_W),
        .DELAY  (DELAY_L)
    ) u_left (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_busy     (o_busy),
        .i_abort    (i_clear),
        .i_clr_addr (clr_addr),
        .i_data     (i_data_L),
        .i_dv       (i_L_DV),
        .i_wet_gain (i_wet_gain),
        .i_fb_gain  (i_fb_gain),
        .i_bypass   (i_bypass),
        .o_echo     (o_echo_L),
        .o_dv       (o_L_DV),
        .o_idle     (l_idle)
    );

    echo_channel #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .GAIN_W (GAIN_W),
        .DELAY  (DELAY_R)
    ) u_right (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_busy     (o_busy),
        .i_abort    (i_clear),
        .i_clr_addr (clr_addr),
        .i_data     (i_data_R),
        .i_dv       (i_R_DV),
        .i_wet_gain (i_wet_gain),
        .i_fb_gain  (i_fb_gain),
        .i_bypass   (i_bypass),
        .o_echo     (o_echo_R),
        .o_dv       (o_R_DV),
        .o_idle     (r_idle)
    );

endmodule

// File: tb/tb_stereo_echo.sv
// tb/tb_stereo_echo.sv - scoreboard bench for stereo_echo
module tb_stereo_echo;

    localparam longint SMAX = 64'sd8388607;
    localparam longint SMIN = -64'sd8388608;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [23:0] data_l = '0;
    logic signed [23:0] data_r = '0;
    logic               dv_l = 1'b0;
    logic               dv_r = 1'b0;
    logic [7:0]         wet = '0;
    logic [7:0]         fb = '0;
    logic               bypass = 1'b0;
    logic               clear = 1'b0;
    logic signed [23:0] echo_l;
    logic signed [23:0] echo_r;
    logic               odv_l;
    logic               odv_r;
    logic               busy;
    logic               overrun;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    int exp_v[2][$];
    int exp_c[2][$];
    int got_v[2][$];
    int got_c[2][$];
    longint mv[2][16];
    int mp[2];
    int dly[2] = '{4, 6};

    stereo_echo #(
        .DATA_W  (24),
        .ADDR_W  (4),
        .DELAY_L (4),
        .DELAY_R (6),
        .GAIN_W  (8)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_data_L   (data_l),
        .i_data_R   (data_r),
        .i_L_DV     (dv_l),
        .i_R_DV     (dv_r),
        .i_wet_gain (wet),
        .i_fb_gain  (fb),
        .i_bypass   (bypass),
        .i_clear    (clear),
        .o_echo_L   (echo_l),
        .o_echo_R   (echo_r),
        .o_L_DV     (odv_l),
        .o_R_DV     (odv_r),
        .o_busy     (busy),
        .o_overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Collect every output strobe with the cycle it appeared in
    always @(negedge clk) begin
        if (odv_l) begin
            got_v[0].push_back(int'(echo_l));
            got_c[0].push_back(cyc);
        end
        if (odv_r) begin
            got_v[1].push_back(int'(echo_r));
            got_c[1].push_back(cyc);
        end
    end

    function automatic longint bsat(input longint v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    // Reference: y = x + g_w*v[n-D], v[n] = x + g_f*v[n-D], both clamped
    function automatic int model_step(input int c, input int x);
        longint d, wv, fv, y, w;
        d  = mv[c][mp[c]];
        wv = (d * longint'(wet)) >>> 8;
        fv = (d * longint'(fb)) >>> 8;
        y  = bypass ? longint'(x) : bsat(longint'(x) + wv);
        w  = bsat(longint'(x) + fv);
        mv[c][mp[c]] = w;
        mp[c] = (mp[c] + 1) % dly[c];
        return int'(y);
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 16; i++) mv[c][i] = 0;
            mp[c] = 0;
        end
    endtask

    // Drive one accepted strobe (called at posedge+1); expected output is due 3 edges after sampling
    task automatic send(input bit l, input bit r, input int xl, input int xr, input int gap);
        data_l = 24'(xl);
        data_r = 24'(xr);
        dv_l = l;
        dv_r = r;
        if (l) begin
            exp_v[0].push_back(model_step(0, xl));
            exp_c[0].push_back(cyc + 4);
        end
        if (r) begin
            exp_v[1].push_back(model_step(1, xr));
            exp_c[1].push_back(cyc + 4);
        end
        @(posedge clk); #1;
        dv_l = 1'b0;
        dv_r = 1'b0;
        repeat (gap - 1) @(posedge clk);
        #1;
    endtask

    task automatic do_clear(output bit ok);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        model_clear();
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1 || odv_l !== 1'b0 || odv_r !== 1'b0 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: busy=%b dv=%b%b ovr=%b, required busy=1 dv=00 ovr=0", busy, odv_l, odv_r, overrun);
        end
        n_cmp++;
        if (echo_l !== 24'sd0 || echo_r !== 24'sd0) begin
            n_bad++;
            $display("FAIL reset_echo: L=%0d R=%0d, required 0 0", echo_l, echo_r);
        end
        rst_n = 1'b1;
        model_clear();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                data_l = 24'sd5000;
                dv_l = 1'b1;
            end else begin
                dv_l = 1'b0;
            end
            if (!busy) break;
            n++;
        end
        dv_l = 1'b0;
        n_cmp++;
        if (n !== 6) begin
            n_bad++;
            $display("FAIL reset_busy_len: busy cycles %0d, required 6", n);
        end
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (got_v[0].size() != 0 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_dv_ignored: outputs %0d overrun %b, required 0 0", got_v[0].size(), overrun);
        end
        got_v[0].delete();
        got_c[0].delete();
    endtask

    task automatic test_impulse();
        int ev, ec, gv, gc;
        int xs[11] = '{1000, 0, 0, 0, 0, 0, -1000, 0, 0, 0, 0};
        wet = 8'd128;
        fb = 8'd0;
        bypass = 1'b0;
        foreach (xs[i]) send(1'b1, 1'b0, xs[i], 0, 6);
        repeat (4) @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            while (exp_v[c].size() > 0) begin
                ev = exp_v[c].pop_front();
                ec = exp_c[c].pop_front();
                n_cmp++;
                if (got_v[c].size() == 0) begin
                    n_bad++;
                    $display("FAIL impulse ch%0d: no output, required %0d @%0d", c, ev, ec);
                end else begin
                    gv = got_v[c].pop_front();
                    gc = got_c[c].pop_front();
                    if (gv !== ev || gc !== ec) begin
                        n_bad++;
                        $display("FAIL impulse ch%0d: got %0d @%0d, required %0d @%0d", c, gv, gc, ev, ec);
                    end
                end
            end
            n_cmp++;
            if (got_v[c].size() != 0) begin
                n_bad++;
                $display("FAIL impulse_extra ch%0d: %0d extra outputs, required 0", c, got_v[c].size());
                got_v[c].delete();
                got_c[c].delete();
            end
        end
    endtask

    task automatic test_feedback();
        bit ok;
        int ev, ec, gv, gc;
        do_clear(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL feedback_clear: busy still %b, required 0", busy);
        end
        wet = 8'd128;
        fb = 8'd128;
        send(1'b1, 1'b0, 1024, 0, 6);
        for (int i = 0; i < 8; i++) send(1'b1, 1'b0, 0, 0, 6);
        repeat (4) @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            while (exp_v[c].size() > 0) begin
                ev = exp_v[c].pop_front();
                ec = exp_c[c].pop_front();
                n_cmp++;
                if (got_v[c].size() == 0) begin
                    n_bad++;
                    $display("FAIL feedback ch%0d: no output, required %0d @%0d", c, ev, ec);
                end else begin
                    gv = got_v[c].pop_front();
                    gc = got_c[c].pop_front();
                    if (gv !== ev || gc !== ec) begin
                        n_bad++;
                        $display("FAIL feedback ch%0d: got %0d @%0d, required %0d @%0d", c, gv, gc, ev, ec);
                    end
                end
            end
            n_cmp++;
            if (got_v[c].size() != 0) begin
                n_bad++;
                $display("FAIL feedback_extra ch%0d: %0d extra outputs, required 0", c, got_v[c].size());
                got_v[c].delete();
                got_c[c].delete();
            end
        end
    endtask

    task automatic test_saturation();
        bit ok;
        int ev, ec, gv, gc;
        int xl[7] = '{8000000, 0, 0, 0, 8000000, 0, 0};
        int xr[7] = '{-8000000, 0, 0, 0, 0, 0, -8000000};
        do_clear(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL sat_clear: busy still %b, required 0", busy);
        end
        wet = 8'd255;
        fb = 8'd255;
        foreach (xl[i]) send(1'b1, 1'b1, xl[i], xr[i], 6);
        repeat (4) @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            while (exp_v[c].size() > 0) begin
                ev = exp_v[c].pop_front();
                ec = exp_c[c].pop_front();
                n_cmp++;
                if (got_v[c].size() == 0) begin
                    n_bad++;
                    $display("FAIL saturation ch%0d: no output, required %0d @%0d", c, ev, ec);
                end else begin
                    gv = got_v[c].pop_front();
                    gc = got_c[c].pop_front();
                    if (gv !== ev || gc !== ec) begin
                        n_bad++;
                        $display("FAIL saturation ch%0d: got %0d @%0d, required %0d @%0d", c, gv, gc, ev, ec);
                    end
                end
            end
            n_cmp++;
            if (got_v[c].size() != 0) begin
                n_bad++;
                $display("FAIL saturation_extra ch%0d: %0d extra outputs, required 0", c, got_v[c].size());
                got_v[c].delete();
                got_c[c].delete();
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int ev, ec, gv, gc;
        do_clear(ok);
        wet = 8'd128;
        fb = 8'd64;
        for (int i = 0; i < 10; i++) send(1'b1, 1'b1, 300 * (i + 1), -200 * i, 4);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (!ok || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_overrun: overrun %b clear_ok %b, required 0 1", overrun, ok);
        end
        for (int c = 0; c < 2; c++) begin
            while (exp_v[c].size() > 0) begin
                ev = exp_v[c].pop_front();
                ec = exp_c[c].pop_front();
                n_cmp++;
                if (got_v[c].size() == 0) begin
                    n_bad++;
                    $display("FAIL back_to_back ch%0d: no output, required %0d @%0d", c, ev, ec);
                end else begin
                    gv = got_v[c].pop_front();
                    gc = got_c[c].pop_front();
                    if (gv !== ev || gc !== ec) begin
                        n_bad++;
                        $display("FAIL back_to_back ch%0d: got %0d @%0d, required %0d @%0d", c, gv, gc, ev, ec);
                    end
                end
            end
            n_cmp++;
            if (got_v[c].size() != 0) begin
                n_bad++;
                $display("FAIL back_to_back_extra ch%0d: %0d extra outputs, required 0", c, got_v[c].size());
                got_v[c].delete();
                got_c[c].delete();
            end
        end
    endtask

    task automatic test_stereo();
        int ev, ec, gv, gc;
        data_l = 24'sd4100;
        data_r = -24'sd2500;
        dv_l = 1'b1;
        dv_r = 1'b1;
        exp_v[0].push_back(model_step(0, 4100));
        exp_c[0].push_back(cyc + 4);
        exp_v[1].push_back(model_step(1, -2500));
        exp_c[1].push_back(cyc + 4);
        @(posedge clk); #1;
        dv_r = 1'b0;
        data_l = 24'sd777;
        @(posedge clk); #1;
        dv_l = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL stereo_overrun: overrun %b, required 1", overrun);
        end
        for (int c = 0; c < 2; c++) begin
            while (exp_v[c].size() > 0) begin
                ev = exp_v[c].pop_front();
                ec = exp_c[c].pop_front();
                n_cmp++;
                if (got_v[c].size() == 0) begin
                    n_bad++;
                    $display("FAIL stereo ch%0d: no output, required %0d @%0d", c, ev, ec);
                end else begin
                    gv = got_v[c].pop_front();
                    gc = got_c[c].pop_front();
                    if (gv !== ev || gc !== ec) begin
                        n_bad++;
                        $display("FAIL stereo ch%0d: got %0d @%0d, required %0d @%0d", c, gv, gc, ev, ec);
                    end
                end
            end
            n_cmp++;
            if (got_v[c].size() != 0) begin
                n_bad++;
                $display("FAIL stereo_extra ch%0d: %0d extra outputs, required 0", c, got_v[c].size());
                got_v[c].delete();
                got_c[c].delete();
            end
        end
    endtask

    task automatic test_bypass();
        bit ok;
        int ev, ec, gv, gc;
        do_clear(ok);
        wet = 8'd128;
        fb = 8'd128;
        bypass = 1'b1;
        send(1'b1, 1'b0, 1000, 0, 6);
        for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 0, 0, 6);
        bypass = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 0, 0, 6);
        repeat (4) @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            while (exp_v[c].size() > 0) begin
                ev = exp_v[c].pop_front();
                ec = exp_c[c].pop_front();
                n_cmp++;
                if (got_v[c].size() == 0) begin
                    n_bad++;
                    $display("FAIL bypass ch%0d: no output, required %0d @%0d", c, ev, ec);
                end else begin
                    gv = got_v[c].pop_front();
                    gc = got_c[c].pop_front();
                    if (gv !== ev || gc !== ec) begin
                        n_bad++;
                        $display("FAIL bypass ch%0d: got %0d @%0d, required %0d @%0d", c, gv, gc, ev, ec);
                    end
                end
            end
            n_cmp++;
            if (got_v[c].size() != 0) begin
                n_bad++;
                $display("FAIL bypass_extra ch%0d: %0d extra outputs, required 0", c, got_v[c].size());
                got_v[c].delete();
                got_c[c].delete();
            end
        end
    endtask

    task automatic test_clear_abort();
        bit ok;
        int n, ev, ec, gv, gc;
        do_clear(ok);
        wet = 8'd128;
        fb = 8'd0;
        for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 2000, 0, 6);
        data_l = 24'sd700;
        dv_l = 1'b1;
        @(posedge clk); #1;
        dv_l = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (!busy) break;
            n++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (n !== 6) begin
            n_bad++;
            $display("FAIL clear_busy_len: busy cycles %0d, required 6", n);
        end
        model_clear();
        for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 0, 0, 6);
        send(1'b1, 1'b0, 300, 0, 6);
        repeat (4) @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            while (exp_v[c].size() > 0) begin
                ev = exp_v[c].pop_front();
                ec = exp_c[c].pop_front();
                n_cmp++;
                if (got_v[c].size() == 0) begin
                    n_bad++;
                    $display("FAIL clear_abort ch%0d: no output, required %0d @%0d", c, ev, ec);
                end else begin
                    gv = got_v[c].pop_front();
                    gc = got_c[c].pop_front();
                    if (gv !== ev || gc !== ec) begin
                        n_bad++;
                        $display("FAIL clear_abort ch%0d: got %0d @%0d, required %0d @%0d", c, gv, gc, ev, ec);
                    end
                end
            end
            n_cmp++;
            if (got_v[c].size() != 0) begin
                n_bad++;
                $display("FAIL clear_abort_extra ch%0d: %0d extra outputs, required 0", c, got_v[c].size());
                got_v[c].delete();
                got_c[c].delete();
            end
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        int ev, ec, gv, gc;
        data_l = 24'sd999;
        dv_l = 1'b1;
        @(posedge clk); #1;
        dv_l = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b1 || overrun !== 1'b0 || echo_l !== 24'sd0 || odv_l !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: busy=%b ovr=%b echo=%0d dv=%b, required 1 0 0 0", busy, overrun, echo_l, odv_l);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL async_reset_sweep: busy still %b, required 0", busy);
        end
        model_clear();
        send(1'b1, 1'b1, 123, -77, 6);
        repeat (4) @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            while (exp_v[c].size() > 0) begin
                ev = exp_v[c].pop_front();
                ec = exp_c[c].pop_front();
                n_cmp++;
                if (got_v[c].size() == 0) begin
                    n_bad++;
                    $display("FAIL async_reset ch%0d: no output, required %0d @%0d", c, ev, ec);
                end else begin
                    gv = got_v[c].pop_front();
                    gc = got_c[c].pop_front();
                    if (gv !== ev || gc !== ec) begin
                        n_bad++;
                        $display("FAIL async_reset ch%0d: got %0d @%0d, required %0d @%0d", c, gv, gc, ev, ec);
                    end
                end
            end
            n_cmp++;
            if (got_v[c].size() != 0) begin
                n_bad++;
                $display("FAIL async_reset_extra ch%0d: %0d extra outputs, required 0", c, got_v[c].size());
                got_v[c].delete();
                got_c[c].delete();
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        @(posedge clk); #1;
        test_impulse();
        test_feedback();
        test_saturation();
        test_back_to_back();
        test_stereo();
        test_bypass();
        test_clear_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
